// File: rtl/udma_hyper_eot_router.sv
// udma_hyper_eot_router
//
// Routes HyperBus end-of-transfer pulses to per-channel, per-direction uDMA
// events. Every transaction issued to the HyperBus core pushes a tag
// {channel, read} into a circular FIFO. Each eot_i pulse pops the oldest tag,
// and the next cycle pulses the matching evt_rx_eot_o / evt_tx_eot_o bit.
//
// Ports:
//   sys_clk_i, rstn_i    clock, asynchronous active-low reset
//   issue_valid_i        transaction issued this cycle
//   issue_ch_i           channel of the issued transaction
//   issue_read_i         1 = read (RX), 0 = write (TX)
//   issue_ready_o        tag FIFO not full
//   eot_i                end-of-transfer pulse from the core
//   evt_rx_eot_o         one-cycle read-completion event per channel
//   evt_tx_eot_o         one-cycle write-completion event per channel
//   pending_o, busy_o    outstanding tag count, count != 0
//   last_read_o          direction of the most recently completed transaction
//   err_issue_o          sticky: issue dropped (full or channel out of range)
//   err_eot_o            sticky: eot_i with no outstanding tag
//   err_clr_i            synchronous clear of both sticky errors
module udma_hyper_eot_router #(
  parameter int unsigned NB_CH = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CH_W  = (NB_CH > 1) ? $clog2(NB_CH) : 1,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             sys_clk_i,
  input  logic             rstn_i,
  input  logic             issue_valid_i,
  input  logic [CH_W-1:0]  issue_ch_i,
  input  logic             issue_read_i,
  output logic             issue_ready_o,
  input  logic             eot_i,
  output logic [NB_CH-1:0] evt_rx_eot_o,
  output logic [NB_CH-1:0] evt_tx_eot_o,
  output logic [CNT_W-1:0] pending_o,
  output logic             busy_o,
  output logic             last_read_o,
  output logic             err_issue_o,
  output logic             err_eot_o,
  input  logic             err_clr_i
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PtrOne = 1;
  localparam logic [CH_W:0]  NbChL  = NB_CH[CH_W:0];
  localparam logic [NB_CH-1:0] EvtOne = 1;

  // Pointers carry an extra wrap bit to tell full from empty.
  logic [PTR_W:0]    wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [CH_W-1:0]   ch_mem [DEPTH];
  logic [DEPTH-1:0]  read_mem;

  logic              full, empty, ch_ok;
  logic              push, drop, pop, spur;
  logic [CH_W-1:0]   head_ch;
  logic              head_read;
  logic [NB_CH-1:0]  head_oh;

  logic [NB_CH-1:0]  evt_rx_q, evt_tx_q;
  logic [CNT_W-1:0]  pending_q;
  logic              busy_q, last_read_q, err_issue_q, err_eot_q;

  always_comb begin
    full      = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
    empty     = (wr_ptr_q == rd_ptr_q);
    ch_ok     = ({1'b0, issue_ch_i} < NbChL);
    push      = issue_valid_i & ~full & ch_ok;
    drop      = issue_valid_i & ~(~full & ch_ok);
    pop       = eot_i & ~empty;
    spur      = eot_i & empty;
    head_ch   = ch_mem[rd_ptr_q[PTR_W-1:0]];
    head_read = read_mem[rd_ptr_q[PTR_W-1:0]];
    head_oh   = EvtOne << head_ch;
    wr_ptr_d  = push ? (wr_ptr_q + PtrOne) : wr_ptr_q;
    rd_ptr_d  = pop ? (rd_ptr_q + PtrOne) : rd_ptr_q;
  end

  // Tag storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge sys_clk_i) begin
    if (push) begin
      ch_mem[wr_ptr_q[PTR_W-1:0]]   <= issue_ch_i;
      read_mem[wr_ptr_q[PTR_W-1:0]] <= issue_read_i;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      evt_rx_q    <= '0;
      evt_tx_q    <= '0;
      pending_q   <= '0;
      busy_q      <= 1'b0;
      last_read_q <= 1'b0;
      err_issue_q <= 1'b0;
      err_eot_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      evt_rx_q  <= (pop && head_read) ? head_oh : '0;
      evt_tx_q  <= (pop && !head_read) ? head_oh : '0;
      pending_q <= CNT_W'(wr_ptr_d - rd_ptr_d);
      busy_q    <= (wr_ptr_d != rd_ptr_d);
      if (pop) begin
        last_read_q <= head_read;
      end
      // A new error in the same cycle wins over the clear.
      if (drop) begin
        err_issue_q <= 1'b1;
      end else if (err_clr_i) begin
        err_issue_q <= 1'b0;
      end
      if (spur) begin
        err_eot_q <= 1'b1;
      end else if (err_clr_i) begin
        err_eot_q <= 1'b0;
      end
    end
  end

  assign issue_ready_o = ~full;
  assign evt_rx_eot_o  = evt_rx_q;
  assign evt_tx_eot_o  = evt_tx_q;
  assign pending_o     = pending_q;
  assign busy_o        = busy_q;
  assign last_read_o   = last_read_q;
  assign err_issue_o   = err_issue_q;
  assign err_eot_o     = err_eot_q;

endmodule

// File: tb/tb_udma_hyper_eot_router.sv
// Testbench for udma_hyper_eot_router. NB_CH=3 so that an out-of-range
// channel index (3) is representable on the 2-bit channel port.
module tb_udma_hyper_eot_router;

  localparam int unsigned NB_CH = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CH_W  = 2;
  localparam int unsigned CNT_W = 3;

  typedef struct {
    int ch;
    bit rd;
  } tag_t;

  logic             sys_clk = 1'b0;
  logic             rstn = 1'b0;
  logic             issue_valid = 1'b0;
  logic [CH_W-1:0]  issue_ch = '0;
  logic             issue_read = 1'b0;
  logic             issue_ready;
  logic             eot = 1'b0;
  logic [NB_CH-1:0] evt_rx, evt_tx;
  logic [CNT_W-1:0] pending;
  logic             busy, last_read, err_issue, err_eot;
  logic             err_clr = 1'b0;

  int   n_pass = 0;
  int   n_total = 0;
  tag_t mq[$];     // reference tag FIFO
  tag_t exp_q[$];  // events expected at the next negedge

  udma_hyper_eot_router #(
    .NB_CH(NB_CH),
    .DEPTH(DEPTH)
  ) dut (
    .sys_clk_i    (sys_clk),
    .rstn_i       (rstn),
    .issue_valid_i(issue_valid),
    .issue_ch_i   (issue_ch),
    .issue_read_i (issue_read),
    .issue_ready_o(issue_ready),
    .eot_i        (eot),
    .evt_rx_eot_o (evt_rx),
    .evt_tx_eot_o (evt_tx),
    .pending_o    (pending),
    .busy_o       (busy),
    .last_read_o  (last_read),
    .err_issue_o  (err_issue),
    .err_eot_o    (err_eot),
    .err_clr_i    (err_clr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Apply one cycle of stimulus; outputs are valid when this returns.
  task automatic step(input bit v, input int ch, input bit rd, input bit e, input bit clr);
    bit   full_m;
    tag_t t;
    issue_valid = v;
    issue_ch    = ch[CH_W-1:0];
    issue_read  = rd;
    eot         = e;
    err_clr     = clr;
    @(posedge sys_clk);
    full_m = (mq.size() == DEPTH);
    if (e && mq.size() != 0) begin
      t = mq.pop_front();
      exp_q.push_back(t);
    end
    if (v && !full_m && ch < NB_CH) begin
      t.ch = ch;
      t.rd = rd;
      mq.push_back(t);
    end
    #1;
    issue_valid = 1'b0;
    issue_ch    = '0;
    issue_read  = 1'b0;
    eot         = 1'b0;
    err_clr     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // Monitor: any event, or any expected event, is checked at every negedge.
  always @(negedge sys_clk) begin
    tag_t t;
    logic [NB_CH-1:0] xr, xt;
    if (rstn && (exp_q.size() != 0 || (evt_rx | evt_tx) != '0)) begin
      if (exp_q.size() == 0) begin
        xr = '0;
        xt = '0;
      end else begin
        t  = exp_q.pop_front();
        xr = t.rd ? (NB_CH'(1) << t.ch) : '0;
        xt = t.rd ? '0 : (NB_CH'(1) << t.ch);
      end
      chk("evt", {16'(evt_rx), 16'(evt_tx)}, {16'(xr), 16'(xt)});
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_evt_rx"}, 32'(evt_rx), 0);
    chk({tag, "_evt_tx"}, 32'(evt_tx), 0);
    chk({tag, "_pending"}, 32'(pending), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_last_read"}, 32'(last_read), 0);
    chk({tag, "_err_issue"}, 32'(err_issue), 0);
    chk({tag, "_err_eot"}, 32'(err_eot), 0);
    chk({tag, "_ready"}, 32'(issue_ready), 1);
  endtask

  initial begin
    #12;
    chk_reset_vals("rst");
    @(posedge sys_clk);
    #1 rstn = 1'b1;

    // Single read on ch1, eot three cycles later.
    step(1, 1, 1, 0, 0);
    chk("t1_pending1", 32'(pending), 1);
    chk("t1_busy1", 32'(busy), 1);
    idle(2);
    chk("t1_no_early_evt", 32'(evt_rx | evt_tx), 0);
    step(0, 0, 0, 1, 0);
    chk("t1_evt_rx", 32'(evt_rx), 32'h2);
    chk("t1_last_read", 32'(last_read), 1);
    chk("t1_pending0", 32'(pending), 0);
    idle(1);
    chk("t1_evt_width", 32'(evt_rx), 0);

    // Ordering: W0, R1, W1, R0 then back-to-back eots.
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    chk("t2_pending4", 32'(pending), 4);
    chk("t2_ready0", 32'(issue_ready), 0);
    step(0, 0, 0, 1, 0);
    chk("t2_evt_tx0", 32'(evt_tx), 32'h1);
    step(0, 0, 0, 1, 0);
    chk("t2_evt_rx1", 32'(evt_rx), 32'h2);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("t2_pending0", 32'(pending), 0);
    chk("t2_last_read", 32'(last_read), 1);
    idle(1);

    // Full and wrap.
    step(1, 2, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 2, 1, 0, 0);
    chk("t3_ready0", 32'(issue_ready), 0);
    step(1, 0, 1, 0, 0);
    chk("t3_err_issue", 32'(err_issue), 1);
    chk("t3_pending_full", 32'(pending), 4);
    step(0, 0, 0, 0, 1);
    chk("t3_err_clr", 32'(err_issue), 0);
    // Pop + push on full: push dropped, count falls to 3.
    step(1, 1, 1, 1, 0);
    chk("t3_full_pp_pending", 32'(pending), 3);
    chk("t3_full_pp_err", 32'(err_issue), 1);
    chk("t3_ready_after", 32'(issue_ready), 1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step(1, i % 3, i[0], 1, 0);
      chk("t3_pp_pending", 32'(pending), 3);
    end
    chk("t3_pp_no_err", 32'(err_issue), 0);
    idle(1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("t3_drain", 32'(pending), 0);
    idle(1);

    // Spurious eot, out-of-range channel, set-over-clear, clear.
    step(0, 0, 0, 1, 0);
    chk("t4_err_eot", 32'(err_eot), 1);
    chk("t4_no_evt", 32'(evt_rx | evt_tx), 0);
    step(1, 3, 1, 0, 0);
    chk("t4_err_issue_oor", 32'(err_issue), 1);
    chk("t4_oor_pending", 32'(pending), 0);
    step(0, 0, 0, 1, 1);
    chk("t4_set_over_clr", 32'(err_eot), 1);
    chk("t4_issue_cleared", 32'(err_issue), 0);
    step(0, 0, 0, 0, 1);
    chk("t4_clr_eot", 32'(err_eot), 0);

    // Push and eot together on empty: error, tag still enqueued.
    step(1, 0, 1, 1, 0);
    chk("t5_err_eot", 32'(err_eot), 1);
    chk("t5_pending", 32'(pending), 1);
    chk("t5_no_evt", 32'(evt_rx | evt_tx), 0);
    step(0, 0, 0, 1, 1);
    chk("t5_evt", 32'(evt_rx), 32'h1);
    chk("t5_clr", 32'(err_eot), 0);
    idle(1);

    // Reset with three tags outstanding.
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 2, 0, 0, 0);
    step(1, 3, 0, 0, 0);
    chk("t6_pending3", 32'(pending), 3);
    #2 rstn = 1'b0;
    #1;
    mq.delete();
    chk_reset_vals("t6");
    @(posedge sys_clk);
    #1 rstn = 1'b1;
    step(0, 0, 0, 1, 0);
    chk("t6_err_eot", 32'(err_eot), 1);
    chk("t6_no_evt", 32'(evt_rx | evt_tx), 0);
    idle(2);

    chk("exp_queue_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule
